seq_detector_param: RTL and testbench

- Runtime-programmable serial pattern detector. Successor to the fixed 4-bit Moore detector.
- Supported now:
  - pattern value and length programmable up to PAT_W bits;
  - overlapping or non-overlapping detection mode;
  - input valid strobe (bit gaps allowed);
  - saturating match counter.
- Sits behind a serial bit source (deserialiser or sync-word hunt); o_match feeds framing/control logic.

---
 rtl/seq_detector_param_pkg.sv | 23 ++
 rtl/seq_det_window.sv | 59 +++++
 rtl/seq_detector_param.sv | 149 ++++++++++++++
 tb/tb_seq_detector_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_param_pkg.sv
// rtl/seq_detector_param_pkg.sv - shared state encoding and length clamp helper for seq_detector_param
package seq_detector_param_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DET  = 2'd2
    } state_t;

    localparam int unsigned MIN_LEN = 1;

    // Programmed length 0 behaves as 1; anything above the window size is clamped.
    function automatic int unsigned eff_len(input int unsigned raw, input int unsigned max_len);
        if (raw < MIN_LEN) begin
            return MIN_LEN;
        end
        if (raw > max_len) begin
            return max_len;
        end
        return raw;
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// rtl/seq_det_window.sv - bit history shift register with length-masked pattern compare
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_shift        : accept i_seq into the history this edge
//   i_clr          : synchronous history clear (wins over i_shift)
//   i_seq          : serial bit
//   i_pattern      : latched pattern, bit [len-1] first received
//   i_len          : effective length (1..PAT_W)
//   i_full_next    : window holds len bits once this bit is accepted
//   o_hit          : combinational match for the bit being accepted now
module seq_det_window #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_shift,
    input  logic             i_clr,
    input  logic             i_seq,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_full_next,
    output logic             o_hit
);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [PAT_W-1:0] hist_shift;
    logic [PAT_W-1:0] mask;

    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], i_seq};
        hist_d     = hist_q;
        if (i_clr) begin
            hist_d = '0;
        end else if (i_shift) begin
            hist_d = hist_shift;
        end
    end

    // Only the youngest len bits take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < i_len);
        end
    end

    assign o_hit = i_shift && !i_clr && i_full_next &&
                   (((hist_shift ^ i_pattern) & mask) == '0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial pattern detector with saturating match count
//   i_clk, i_rstn   : clock, asynchronous active-low reset
//   i_en            : enable; IDLE->FILL latches pattern/length/overlap
//   i_pattern       : pattern, bit [len-1] first received
//   i_pat_len       : pattern length (0 acts as 1, >PAT_W clamped)
//   i_overlap       : 1 overlapping, 0 non-overlapping detection
//   i_seq, i_valid  : serial bit and its qualifier
//   i_clr           : synchronous clear of history, fill and counter
//   o_match         : registered one-cycle match pulse
//   o_match_cnt     : saturating match count
//   o_busy          : state is not S_IDLE
//   o_match_early   : combinational match, present only with SEQDET_MEALY_EN
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_pat_len,
    input  logic             i_overlap,
    input  logic             i_seq,
    input  logic             i_valid,
    input  logic             i_clr,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_busy
`ifdef SEQDET_MEALY_EN
    ,
    output logic             o_match_early
`endif
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] fill_inc;
    logic             running;
    logic             shift;
    logic             hist_clr;
    logic             full_next;
    logic             hit;

    assign running     = (state_q != S_IDLE);
    assign shift       = running && i_en && i_valid && !i_clr;
    assign hist_clr    = !i_en || i_clr;
    assign len_clamped = LEN_W'(eff_len(32'(i_pat_len), PAT_W));
    assign fill_inc    = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    assign full_next   = (fill_inc == len_q);

    seq_det_window #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_window (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_shift     (shift),
        .i_clr       (hist_clr),
        .i_seq       (i_seq),
        .i_pattern   (pat_q),
        .i_len       (len_q),
        .i_full_next (full_next),
        .o_hit       (hit)
    );

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        len_d   = len_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;

        if (!i_en) begin
            state_d = S_IDLE;
            fill_d  = '0;
            if (i_clr) begin
                cnt_d = '0;
            end
        end else if (state_q == S_IDLE) begin
            pat_d   = i_pattern;
            len_d   = len_clamped;
            ovl_d   = i_overlap;
            fill_d  = '0;
            state_d = S_FILL;
            if (i_clr) begin
                cnt_d = '0;
            end
        end else if (i_clr) begin
            fill_d  = '0;
            cnt_d   = '0;
            state_d = S_FILL;
        end else if (i_valid) begin
            fill_d = fill_inc;
            if (hit) begin
                match_d = 1'b1;
                if (!(&cnt_q)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Non-overlap restarts the window so the accepting bit is not reused.
            if (hit && !ovl_q) begin
                fill_d  = '0;
                state_d = S_FILL;
            end else if (full_next) begin
                state_d = S_DET;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            fill_q  <= '0;
            len_q   <= LEN_W'(1);
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_match     = match_q;
    assign o_match_cnt = cnt_q;
    assign o_busy      = running;
`ifdef SEQDET_MEALY_EN
    assign o_match_early = hit;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - randomized self-checking bench for seq_detector_param
module tb_seq_detector_param;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       overlap;
    logic       seq;
    logic       valid;
    logic       clr;
    logic       match_a, busy_a, match_b, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
`ifdef SEQDET_MEALY_EN
    logic       early_a, early_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit       m_active;
    bit       m_q[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_cnt;
    bit       m_match;

    // Configuration currently presented on the inputs
    bit [7:0] c_pat;
    int       c_len;
    bit       c_ovl;

    seq_detector_param #(.PAT_W(8), .CNT_W(8)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_pattern(pattern), .i_pat_len(pat_len),
        .i_overlap(overlap), .i_seq(seq), .i_valid(valid), .i_clr(clr),
        .o_match(match_a), .o_match_cnt(cnt_a), .o_busy(busy_a)
`ifdef SEQDET_MEALY_EN
        , .o_match_early(early_a)
`endif
    );

    seq_detector_param #(.PAT_W(8), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_pattern(pattern), .i_pat_len(pat_len),
        .i_overlap(overlap), .i_seq(seq), .i_valid(valid), .i_clr(clr),
        .o_match(match_b), .o_match_cnt(cnt_b), .o_busy(busy_b)
`ifdef SEQDET_MEALY_EN
        , .o_match_early(early_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("match", 32'(match_a), 32'(m_match));
        check("cnt", 32'(cnt_a), 32'((m_cnt > 255) ? 255 : m_cnt));
        check("busy", 32'(busy_a), 32'(m_active));
        check("match_c2", 32'(match_b), 32'(m_match));
        check("cnt_c2", 32'(cnt_b), 32'((m_cnt > 3) ? 3 : m_cnt));
        check("busy_c2", 32'(busy_b), 32'(m_active));
    endtask

    task automatic model_reset();
        m_active = 0;
        m_q.delete();
        m_cnt    = 0;
        m_match  = 0;
    endtask

    // Pattern match over the list of bits received since the window was last emptied.
    task automatic model_step(input bit s_en, input bit s_clr, input bit s_valid, input bit s_seq);
        bit ok;
        m_match = 0;
        if (!s_en) begin
            m_active = 0;
            m_q.delete();
            if (s_clr) m_cnt = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_pat    = c_pat;
            m_len    = (c_len == 0) ? 1 : (c_len > 8) ? 8 : c_len;
            m_ovl    = c_ovl;
            m_q.delete();
            if (s_clr) m_cnt = 0;
        end else if (s_clr) begin
            m_q.delete();
            m_cnt = 0;
        end else if (s_valid) begin
            m_q.push_back(s_seq);
            if (m_q.size() > 8) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
                ok = 1;
                for (int k = 0; k < m_len; k++) begin
                    if (m_q[m_q.size() - m_len + k] != m_pat[m_len - 1 - k]) ok = 0;
                end
                if (ok) begin
                    m_match = 1;
                    m_cnt++;
                    if (!m_ovl) m_q.delete();
                end
            end
        end
    endtask

    task automatic cycle(input bit s_en, input bit s_clr, input bit s_valid, input bit s_seq);
        @(negedge clk);
        compare_outputs();
        en      = s_en;
        clr     = s_clr;
        valid   = s_valid;
        seq     = s_seq;
        pattern = c_pat;
        pat_len = 4'(c_len);
        overlap = c_ovl;
        model_step(s_en, s_clr, s_valid, s_seq);
`ifdef SEQDET_MEALY_EN
        #1;
        check("early", 32'(early_a), 32'(m_match));
        check("early_c2", 32'(early_b), 32'(m_match));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn  = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        valid = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        repeat (2) begin
            @(negedge clk);
            compare_outputs();
        end
        rstn = 1'b1;
    endtask

    task automatic feed(input bit [7:0] bits, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1, 0, 1, bits[i]);
            if (gaps) cycle(1, 0, 0, 0);
        end
    endtask

    task automatic configure(input bit [7:0] p, input int l, input bit o);
        cycle(0, 1, 0, 0);
        c_pat = p;
        c_len = l;
        c_ovl = o;
        cycle(1, 0, 0, 0);
    endtask

    initial begin
        rstn = 1'b0; en = 0; clr = 0; valid = 0; seq = 0;
        pattern = '0; pat_len = '0; overlap = 0;
        c_pat = 0; c_len = 0; c_ovl = 0;
        model_reset();
        do_reset();

        // Overlapping 1011 over 1,0,1,1,0,1,1
        configure(8'b1011, 4, 1);
        feed(8'b1011011, 7, 0);
        cycle(1, 0, 0, 0);
        check("ovl_cnt", 32'(cnt_a), 2);

        // Non-overlapping, same stream
        configure(8'b1011, 4, 0);
        feed(8'b1011011, 7, 0);
        cycle(1, 0, 0, 0);
        check("novl_cnt", 32'(cnt_a), 1);

        // Gaps between bits
        configure(8'b1011, 4, 1);
        feed(8'b1011011, 7, 1);
        check("gap_cnt", 32'(cnt_a), 2);

        // Saturation on the 2-bit counter
        configure(8'b1, 1, 1);
        feed(8'b11111, 5, 0);
        cycle(1, 0, 0, 0);
        check("sat_c2", 32'(cnt_b), 3);
        check("sat_c8", 32'(cnt_a), 5);

        // Length 0 acts as 1; length 15 clamps to 8
        configure(8'b1, 0, 1);
        feed(8'b01, 2, 0);
        cycle(1, 0, 0, 0);
        check("len0_cnt", 32'(cnt_a), 1);
        configure(8'hA5, 15, 1);
        feed(8'hA5, 8, 0);
        cycle(1, 0, 0, 0);
        check("len15_cnt", 32'(cnt_a), 1);

        // Reset mid-stream loses the partial window
        configure(8'b1011, 4, 1);
        feed(8'b101, 3, 0);
        do_reset();
        cycle(1, 0, 1, 1);
        cycle(1, 0, 0, 0);
        check("rst_nomatch", 32'(cnt_a), 0);
        feed(8'b1011, 4, 0);
        cycle(1, 0, 0, 0);
        check("rst_refill", 32'(cnt_a), 1);

        // Clear together with the accepting bit
        feed(8'b101, 3, 0);
        cycle(1, 1, 1, 1);
        cycle(1, 0, 0, 0);
        check("clr_match", 32'(match_a), 0);
        check("clr_cnt", 32'(cnt_a), 0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                c_pat = 8'($urandom);
                c_len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
                c_ovl = 1'($urandom);
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) < 7, 1'($urandom));
        end

        @(negedge clk);
        compare_outputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
